divider_sequential: RTL

//  Iterative restoring divider, the inverse datapath of the pipelined array multiplier.

---
 rtl/divider_sequential.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/divider_sequential.sv
// rtl/divider_sequential.sv - iterative restoring divider, one quotient bit per clock; DIV_SIGNED_EN selects two's complement operation
module divider_sequential #(
  parameter int width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int cw = $clog2(width);
  localparam logic [cw-1:0] last_iter = cw'(width - 1);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_busy = 2'd1,
    st_done = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [cw-1:0]    cnt;
  logic [width-1:0] dvd;
  logic [width-1:0] dvs;
  logic [width-1:0] rem;
  logic             dbz;
  logic [width:0]   shifted;
  logic [width:0]   trial;
  logic [width-1:0] a_mag;
  logic [width-1:0] b_mag;
  logic [width-1:0] q_fin;
  logic [width-1:0] r_fin;
  logic             accept;

  assign in_ready = (state == st_idle);
  assign accept   = in_ready && in_valid;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Operands enter the loop as magnitudes; the most-negative value maps onto itself as an unsigned magnitude.
  always_comb begin
    a_mag = a[width-1] ? -a : a;
    b_mag = b[width-1] ? -b : b;
  end

  // Quotient is negative when signs differ, remainder follows the dividend; divide by zero forces q to -1.
  always_comb begin
    q_fin = neg_q ? -dvd : dvd;
    r_fin = neg_r ? -rem : rem;
    if (dbz) begin
      q_fin = '1;
    end
  end

  // Operand signs are captured alongside the magnitudes at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= a[width-1] ^ b[width-1];
      neg_r <= a[width-1];
    end
  end
`else
  assign a_mag = a;
  assign b_mag = b;
  assign q_fin = dvd;
  assign r_fin = rem;
`endif

  // Trial subtraction is one bit wider than the operands so its top bit is the borrow.
  always_comb begin
    shifted = {rem, dvd[width-1]};
    trial   = shifted - {1'b0, dvs};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: idle until accept, width iterations, then hold the result until it is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle: begin
        if (in_valid) begin
          state_nxt = st_busy;
        end
      end
      st_busy: begin
        if (cnt == '0) begin
          state_nxt = st_done;
        end
      end
      st_done: begin
        if (out_valid && out_ready) begin
          state_nxt = st_idle;
        end
      end
      default: state_nxt = st_idle;
    endcase
  end

  // Datapath: load operands on accept, then shift {rem, dvd} and restore on borrow; quotient bits fill dvd from the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      dbz <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (in_valid) begin
            dvd <= a_mag;
            dvs <= b_mag;
            rem <= '0;
            dbz <= (b == '0);
            cnt <= last_iter;
          end
        end
        st_busy: begin
          if (trial[width]) begin
            rem <= shifted[width-1:0];
          end else begin
            rem <= trial[width-1:0];
          end
          dvd <= {dvd[width-2:0], ~trial[width]};
          if (cnt != '0) begin
            cnt <= cnt - cw'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result register: loaded once on the first done cycle, held until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else if (state == st_done && !out_valid) begin
      q           <= q_fin;
      r           <= r_fin;
      div_by_zero <= dbz;
      out_valid   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule
